// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the two-port memory arbiter: word size,
// timeout default, wait-counter width and FSM state encodings.
package mem_port_arbiter_pkg;

    localparam int WORD_SIZE_DEFAULT = 16;
    localparam int TIMEOUT_DEFAULT   = 255;
    localparam int WAIT_CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DREAD  = 3'd2,
        ST_DWRITE = 3'd3,
        ST_DONE   = 3'd4
    } arb_state_t;

    function automatic logic is_access_state(input arb_state_t st);
        return (st == ST_FETCH) || (st == ST_DREAD) || (st == ST_DWRITE);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin pick between the fetch and data requesters; on a tie
// the requester that was not served last wins.
module arb_rr2 (
    input  logic i_req,
    input  logic d_req,
    input  logic last_was_data,
    output logic grant_valid,
    output logic grant_data
);

    assign grant_valid = i_req | d_req;
    assign grant_data  = d_req & (~i_req | ~last_was_data);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto a single memory
// bus with read/write strobes, a shared tri-state data bus and an access timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    output logic                 err
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

    arb_state_t state;
    arb_state_t state_next;

    logic [WORD_SIZE-1:0]  addr_q;
    logic [WORD_SIZE-1:0]  wdata_q;
    logic                  served_data_q;
    logic                  last_was_data;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    logic grant_valid;
    logic grant_data;
    logic in_access;
    logic timeout_hit;
    logic access_end;

    arb_rr2 u_arb (
        .i_req         (i_req),
        .d_req         (d_req),
        .last_was_data (last_was_data),
        .grant_valid   (grant_valid),
        .grant_data    (grant_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An access ends either on the memory handshake or when the wait budget runs out.
    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        access_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    if (grant_data) begin
                        state_next = d_we ? ST_DWRITE : ST_DREAD;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH, ST_DREAD, ST_DWRITE: begin
                if (inputReady) begin
                    state_next = ST_DONE;
                    access_end = 1'b1;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    state_next  = ST_DONE;
                    access_end  = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign in_access = is_access_state(state);
    assign readM     = (state == ST_FETCH) || (state == ST_DREAD);
    assign writeM    = (state == ST_DWRITE);
    assign address   = in_access ? addr_q : '0;
    assign data      = (state == ST_DWRITE) ? wdata_q : {WORD_SIZE{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            served_data_q <= 1'b0;
            wait_cnt      <= '0;
        end else if (state == ST_IDLE) begin
            if (grant_valid) begin
                addr_q        <= grant_data ? d_addr : i_addr;
                wdata_q       <= d_wdata;
                served_data_q <= grant_data;
                wait_cnt      <= '0;
            end
        end else if (in_access && !inputReady) begin
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
        end
    end

    // Read data is captured on the handshake edge only; a timeout leaves it untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if (inputReady) begin
            if (state == ST_FETCH) begin
                i_rdata <= data;
            end else if (state == ST_DREAD) begin
                d_rdata <= data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_done        <= 1'b0;
            d_done        <= 1'b0;
            err           <= 1'b0;
            last_was_data <= 1'b0;
        end else begin
            i_done <= access_end & ~served_data_q;
            d_done <= access_end & served_data_q;
            err    <= timeout_hit;
            if (state == ST_DONE) begin
                last_was_data <= served_data_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed checks of mem_port_arbiter against a transaction-level
// model of the arbitration, handshake and timeout rules.
module tb_mem_port_arbiter;

    localparam int WS = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [WS-1:0] i_addr;
    logic [WS-1:0] i_rdata;
    logic          i_done;
    logic          d_req;
    logic          d_we;
    logic [WS-1:0] d_addr;
    logic [WS-1:0] d_wdata;
    logic [WS-1:0] d_rdata;
    logic          d_done;
    logic          readM;
    logic          writeM;
    logic [WS-1:0] address;
    wire  [WS-1:0] data;
    logic          inputReady;
    logic          err;

    logic          tb_drive;
    logic [WS-1:0] bus_val;

    assign data = tb_drive ? bus_val : {WS{1'bz}};

    always #5 clk = ~clk;

    mem_port_arbiter #(.WORD_SIZE(WS), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_done     (i_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data       (data),
        .inputReady (inputReady),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = waiting for a grant, 1 = access on the bus, 2 = completion cycle.
    // kind 0 = fetch, 1 = data read, 2 = data write.
    int            m_phase;
    int            m_kind;
    int            m_waited;
    logic [WS-1:0] m_addr;
    logic [WS-1:0] m_wdata;
    logic [WS-1:0] m_i_rdata;
    logic [WS-1:0] m_d_rdata;
    bit            m_i_done;
    bit            m_d_done;
    bit            m_err;
    bit            m_last_data;

    int            lat;
    int            force_lat;
    int            force_ir;
    bit            force_bus;
    logic [WS-1:0] force_bus_val;

    task automatic checkOutput(input string name, input logic [WS-1:0] actual,
                               input logic [WS-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_phase     = 0;
        m_kind      = 0;
        m_waited    = 0;
        m_addr      = '0;
        m_wdata     = '0;
        m_i_rdata   = '0;
        m_d_rdata   = '0;
        m_i_done    = 0;
        m_d_done    = 0;
        m_err       = 0;
        m_last_data = 0;
    endtask

    task automatic pickLatency();
        lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
    endtask

    task automatic modelStep();
        m_i_done = 0;
        m_d_done = 0;
        m_err    = 0;
        case (m_phase)
            0: begin
                if (d_req && (!i_req || !m_last_data)) begin
                    m_kind   = d_we ? 2 : 1;
                    m_addr   = d_addr;
                    m_wdata  = d_wdata;
                    m_phase  = 1;
                    m_waited = 0;
                    pickLatency();
                end else if (i_req) begin
                    m_kind   = 0;
                    m_addr   = i_addr;
                    m_phase  = 1;
                    m_waited = 0;
                    pickLatency();
                end
            end
            1: begin
                if (inputReady) begin
                    if (m_kind == 0) m_i_rdata = bus_val;
                    else if (m_kind == 1) m_d_rdata = bus_val;
                    m_phase  = 2;
                    m_i_done = (m_kind == 0);
                    m_d_done = (m_kind != 0);
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_phase  = 2;
                        m_i_done = (m_kind == 0);
                        m_d_done = (m_kind != 0);
                        m_err    = 1;
                    end
                end
            end
            default: begin
                m_last_data = (m_kind != 0);
                m_phase     = 0;
            end
        endcase
    endtask

    task automatic driveMemory();
        bus_val  = force_bus ? force_bus_val : WS'($urandom);
        tb_drive = !(m_phase == 1 && m_kind == 2);
        if (m_phase == 1) inputReady = (m_waited + 1 == lat);
        else if (force_ir >= 0) inputReady = (force_ir == 1);
        else inputReady = ($urandom_range(0, 3) == 0);
    endtask

    task automatic checkAll();
        bit            acc;
        logic [WS-1:0] exp_data;
        acc      = (m_phase == 1);
        exp_data = (acc && m_kind == 2) ? m_wdata : bus_val;
        checkOutput("readM",   WS'(readM),   WS'(acc && m_kind != 2));
        checkOutput("writeM",  WS'(writeM),  WS'(acc && m_kind == 2));
        checkOutput("address", address,      acc ? m_addr : '0);
        checkOutput("data",    data,         exp_data);
        checkOutput("i_done",  WS'(i_done),  WS'(m_i_done));
        checkOutput("d_done",  WS'(d_done),  WS'(m_d_done));
        checkOutput("err",     WS'(err),     WS'(m_err));
        checkOutput("i_rdata", i_rdata,      m_i_rdata);
        checkOutput("d_rdata", d_rdata,      m_d_rdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) modelStep();
        #1;
        driveMemory();
        @(negedge clk);
        checkAll();
    endtask

    task automatic applyStimulus();
        if (i_req) begin
            if ($urandom_range(0, 7) == 0) i_req = 1'b0;
        end else begin
            i_req = $urandom_range(0, 1) == 1;
        end
        if (d_req) begin
            if ($urandom_range(0, 7) == 0) d_req = 1'b0;
        end else begin
            d_req = $urandom_range(0, 1) == 1;
        end
        d_we    = $urandom_range(0, 1) == 1;
        i_addr  = WS'($urandom);
        d_addr  = WS'($urandom);
        d_wdata = WS'($urandom);
        if (reset) begin
            reset = 1'b0;
        end else if ($urandom_range(0, 499) == 0) begin
            reset = 1'b1;
            modelReset();
        end
    endtask

    initial begin
        int rcnt, wcnt, dcnt, ecnt, both, ng, seen;
        int order [4];
        logic [WS-1:0] last_addr, exp_prev;

        reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; inputReady = 0;
        tb_drive = 1'b1; bus_val = '0;
        force_lat = 0; force_ir = 0; force_bus = 0; force_bus_val = '0; lat = 1;
        modelReset();
        repeat (2) cycle();

        checkOutput("rst_readM",   WS'(readM),  '0);
        checkOutput("rst_writeM",  WS'(writeM), '0);
        checkOutput("rst_address", address,     '0);
        checkOutput("rst_i_rdata", i_rdata,     '0);
        checkOutput("rst_d_rdata", d_rdata,     '0);
        checkOutput("rst_dones",   WS'({i_done, d_done, err}), '0);
        checkOutput("rst_bus_hiz", data,        bus_val);
        reset = 1'b0;

        // Fetch with a three-cycle memory.
        force_lat = 3; force_bus = 1; force_bus_val = 16'h1234;
        i_req = 1; i_addr = 16'h0010;
        rcnt = 0; dcnt = 0; last_addr = '0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (readM) begin rcnt++; last_addr = address; end
            if (i_done) begin dcnt++; i_req = 0; end
        end
        checkOutput("fetch_readM_cycles", WS'(rcnt), 16'd3);
        checkOutput("fetch_address",      last_addr, 16'h0010);
        checkOutput("fetch_done_count",   WS'(dcnt), 16'd1);
        checkOutput("fetch_rdata",        i_rdata,   16'h1234);
        force_bus = 0;

        // Write with a two-cycle memory.
        force_lat = 2; d_req = 1; d_we = 1; d_addr = 16'h0080; d_wdata = 16'hBEEF;
        wcnt = 0; dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (writeM) begin
                wcnt++;
                checkOutput("write_bus", data, 16'hBEEF);
                checkOutput("write_addr", address, 16'h0080);
            end
            if (d_done) begin dcnt++; d_req = 0; end
        end
        checkOutput("write_cycles",     WS'(wcnt), 16'd2);
        checkOutput("write_done_count", WS'(dcnt), 16'd1);
        checkOutput("write_bus_release", data, bus_val);

        // Spurious inputReady while idle.
        force_ir = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checkOutput("spurious_done",  WS'(i_done | d_done), '0);
            checkOutput("spurious_readM", WS'(readM | writeM),  '0);
        end
        force_ir = 0;

        // Contention from reset: data, fetch, data, fetch.
        reset = 1; modelReset(); cycle(); reset = 0;
        force_lat = 1; i_req = 1; d_req = 1; d_we = 0;
        ng = 0;
        for (int k = 0; k < 30 && ng < 4; k++) begin
            cycle();
            if (i_done && ng < 4) begin order[ng] = 0; ng++; end
            if (d_done && ng < 4) begin order[ng] = 1; ng++; end
        end
        i_req = 0; d_req = 0;
        checkOutput("contention_grants", WS'(ng), 16'd4);
        checkOutput("contention_g0", WS'(order[0]), 16'd1);
        checkOutput("contention_g1", WS'(order[1]), 16'd0);
        checkOutput("contention_g2", WS'(order[2]), 16'd1);
        checkOutput("contention_g3", WS'(order[3]), 16'd0);

        // Timeout on a data read that never gets a handshake.
        force_lat = 99; d_req = 1; d_we = 0; d_addr = 16'h0042;
        exp_prev = m_d_rdata;
        rcnt = 0; ecnt = 0; both = 0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (readM) rcnt++;
            if (err) ecnt++;
            if (err && d_done) both++;
            if (d_done) d_req = 0;
        end
        checkOutput("timeout_readM_cycles", WS'(rcnt), 16'd4);
        checkOutput("timeout_err_count",    WS'(ecnt), 16'd1);
        checkOutput("timeout_err_with_done", WS'(both), 16'd1);
        checkOutput("timeout_rdata_kept",   d_rdata,   exp_prev);

        force_lat = 1; d_req = 1; dcnt = 0; ecnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (err) ecnt++;
            if (d_done) begin dcnt++; d_req = 0; end
        end
        checkOutput("after_timeout_done", WS'(dcnt), 16'd1);
        checkOutput("after_timeout_err",  WS'(ecnt), '0);

        // Reset one cycle into a data read.
        force_lat = 99; d_req = 1; d_we = 0; seen = 0;
        for (int k = 0; k < 4 && seen == 0; k++) begin
            cycle();
            if (readM) seen = 1;
        end
        checkOutput("rst_mid_read_started", WS'(seen), 16'd1);
        d_req = 0;
        @(posedge clk);
        #2;
        reset = 1;
        modelReset();
        #1;
        checkOutput("rst_mid_readM",   WS'(readM),  '0);
        checkOutput("rst_mid_d_done",  WS'(d_done), '0);
        checkOutput("rst_mid_address", address,     '0);
        checkOutput("rst_mid_bus_hiz", data,        bus_val);
        @(negedge clk);
        cycle();
        reset = 0;
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (d_done) dcnt++;
        end
        checkOutput("rst_mid_no_done", WS'(dcnt), '0);

        // Randomised traffic.
        force_lat = 0; force_ir = -1;
        for (int k = 0; k < 3000; k++) begin
            applyStimulus();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of address and data words.
REQ-002 Parameter TIMEOUT, default 255: maximum number of cycles to wait for inputReady before aborting an access (8-bit counter).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch request; held high until i_done.
REQ-006 i_addr  input  WORD_SIZE  fetch address.
REQ-007 i_rdata  output  WORD_SIZE  fetched word; valid in the i_done cycle and held until the next fetch completes.
REQ-008 i_done  output  1  one-cycle pulse when a fetch completes.
REQ-009 d_req  input  1  data request; held high until d_done.
REQ-010 d_we  input  1  data request type: 1 = write, 0 = read.
REQ-011 d_addr, d_wdata  input  WORD_SIZE each  data address and store data.
REQ-012 d_rdata  output  WORD_SIZE  load data; valid in the d_done cycle and held until the next data read completes.
REQ-013 d_done  output  1  one-cycle pulse when a data access completes.
REQ-014 readM, writeM  output  1 each  memory read and write strobes.
REQ-015 address  output  WORD_SIZE  memory address.
REQ-016 data  inout  WORD_SIZE  memory data bus.
REQ-017 inputReady  input  1  memory pulse: read data valid, or write accepted.
REQ-018 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-019 FSM states: IDLE, FETCH, DREAD, DWRITE, DONE.
REQ-020 IDLE: with only i_req high, go to FETCH; with only d_req high, go to DREAD when d_we=0 and DWRITE when d_we=1.
REQ-021 IDLE with i_req and d_req both high: grant the requester not served last (last_was_data flag); after reset, data wins.
REQ-022 In IDLE, latch the granted address and write data into registers; requester inputs are ignored until the next IDLE.
REQ-023 readM=1 throughout FETCH and DREAD; writeM=1 throughout DWRITE; both strobes are 0 in IDLE and DONE and are never high together.
REQ-024 address equals the latched address in FETCH/DREAD/DWRITE and 0 otherwise.
REQ-025 data is driven with the latched write data only in DWRITE; otherwise it is high-impedance.
REQ-026 On inputReady in FETCH/DREAD, capture data into i_rdata/d_rdata that same edge; then go to DONE. On inputReady in DWRITE, go to DONE.
REQ-027 DONE lasts one cycle, pulses i_done or d_done for the served requester, updates last_was_data, then returns to IDLE.
REQ-028 Minimum latency: request at edge t, strobe high from t+1, inputReady at t+1 gives a done pulse at t+2 and IDLE at t+3.
REQ-029 inputReady is ignored in IDLE and DONE.
REQ-030 Wait counter: cleared on entry to any access state; increments each access cycle without inputReady.
REQ-031 When the wait counter reaches TIMEOUT: pulse err, pulse the served requester's done, leave the rdata register unchanged, and go to DONE (err and done are in the same cycle).
REQ-032 A requester dropping its req mid-access has no effect; the access completes.

Reset
REQ-033 While reset is high: state=IDLE, readM=writeM=0, address=0, data bus high-impedance, i_rdata=d_rdata=0, i_done=d_done=err=0, wait counter=0, last_was_data=0.
REQ-034 Reset asserted mid-access aborts immediately with no done pulse; after release, the first edge behaves as IDLE.

Structure
REQ-035 WORD_SIZE comes from the shared constants include; FSM state encodings and the TIMEOUT default live in the shared package/include.
REQ-036 One sub-module, arb_rr2: a 2-way round-robin pick from i_req, d_req and last_was_data; the FSM and datapath are flat in mem_port_arbiter.

Verification
REQ-037 Fetch only: i_req, i_addr=0x0010, memory returns 0x1234 after 3 cycles -> readM high 3 cycles, address=0x0010, i_done pulses once, i_rdata=0x1234.
REQ-038 Write: d_req, d_we=1, d_addr=0x0080, d_wdata=0xBEEF -> writeM high, data bus carries 0xBEEF only in DWRITE, d_done after inputReady, bus high-Z afterwards.
REQ-039 Contention: i_req and d_req held high for 4 accesses after reset -> grants alternate data, fetch, data, fetch.
REQ-040 Timeout: TIMEOUT=4, d_req read with inputReady never asserted -> err and d_done pulse together, d_rdata unchanged, next request accepted.
REQ-041 Reset mid-DREAD: assert reset one cycle after readM rises -> readM=0 immediately, no d_done, data bus high-Z.
REQ-042 Spurious inputReady in IDLE -> no state change, no done pulse.
